ssd_display_driver: RTL
=======================

Name: ssd_display_driver

Overview:
- Producer side of the seven-segment decoder interface: turns a binary reaction time or a status message into four 5-bit display codes.
- Time-multiplexes those codes onto one shared code bus, with active-low anode selects for a 4-digit common-anode display.
- Binary-to-BCD conversion is sequential (iterative shift-add-3), so the numeric readout costs no wide combinational divider.
- Sits between the timer control FSM and the seven-segment decoder.

Parameters:
REFRESH_CYCLES, 100000, clk cycles each digit stays selected before the scan advances (minimum 2)
CNT_W, 17, width of the refresh counter; must satisfy 2^CNT_W >= REFRESH_CYCLES

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  one-cycle strobe; samples value and mode
value  input  14  binary reaction time in ms, 0..16383
mode  input  2  0 NUMBER, 1 FAIL message, 2 IdLE message, 3 all blank
blank  input  1  level; forces all anodes off while high
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when new display contents are committed
bcd  output  5  display code for the selected digit; drives the decoder input
an  output  4  active-low anode selects; an[0] = rightmost (units) digit

Behaviour:
- Reset and polarity (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Display codes are fixed codebase-wide: 0-9 digits, 10 F, 11 A, 12 I, 13 L, 14 E, 15 d, 16 OFF, 31 ERR. The decoder renders 31 through its default pattern.
- Reset values: busy=0, done=0, digit index=0, refresh counter=0, all four display registers=OFF(16).
- Consequently, out of reset an=4'b1110 and bcd=5'd16.
- Load acceptance:
  - load is accepted only when busy=0; load while busy=1 is ignored with no effect.
  - On the accepting edge N: latch value into a 30-bit shift register (16 BCD bits, then 14 binary bits), latch mode, set iteration count=14, set busy=1.
- Iterations, edges N+1..N+14:
  - Any BCD nibble >=5 gets +3.
  - Then the whole register shifts left by 1.
- Commit on edge N+14 (uniform latency for all modes):
  - Display registers update atomically; busy clears; done=1 for exactly one cycle (edge N+14 to N+15).
  - The old display remains shown until commit.
  - A new load is accepted at edge N+15 or later.
- Commit contents by mode (digit3..digit0):
  - NUMBER, value<=9999: the BCD digits, with leading-zero blanking. Leading zeros become OFF; digit0 is never blanked, so value 0 shows OFF,OFF,OFF,0.
  - NUMBER, value>9999: all four digits = ERR(31).
  - FAIL: F,A,I,L.
  - IdLE: I,d,L,E.
  - Blank (mode 3): all OFF.
- Scan:
  - The refresh counter increments every cycle; at REFRESH_CYCLES-1 it wraps to 0 and the digit index advances (0,1,2,3,0...).
  - an = ~(4'b0001 << index), or 4'b1111 when blank=1.
  - bcd = display[index] regardless of blank.
  - an and bcd derive only from registered state and the blank input, so they always change together.
  - Scanning continues during conversion and while blank=1.
- Reset mid-conversion aborts immediately to the reset values; a partial result is never committed.
- mode and value are sampled only at the accepting load edge; changes at any other time are ignored.

Test Plan:
- Reset release, REFRESH_CYCLES=4 -> an cycles 1110,1101,1011,0111,1110, each held 4 clk; bcd=16 throughout; busy=0, done=0.
- load with value=1234, mode=0 -> busy high for 14 cycles; done pulses once at edge N+14; then digits 3..0 show codes 1,2,3,4 on their anodes.
- load with value=7, mode=0, then value=0 -> first shows OFF,OFF,OFF,7; second shows OFF,OFF,OFF,0. Check value=9999 -> 9,9,9,9; value=10000 -> 31,31,31,31.
- load with mode=1, then mode=2, then mode=3 -> codes 10,11,12,13, then 12,15,13,14, then 16 on all digits, each after 14-cycle latency.
- Second load pulse 5 cycles into a conversion -> ignored; result matches the first value; exactly one done pulse.
- blank=1 mid-scan -> an=4'b1111 immediately, index keeps advancing; assert rst_n low at iteration 7 -> display stays OFF and busy=0; no done pulse after reset release.

Source files
------------

// File: rtl/ssd_display_driver.sv
// ssd_display_driver
//   Producer side of the seven-segment decoder interface. A load strobe
//   captures a 14-bit reaction time (ms) and a display mode. A sequential
//   shift-add-3 converter turns the time into BCD over 14 clocks. The four
//   resulting 5-bit display codes are then committed atomically and scanned
//   onto one shared code bus with active-low anode selects.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   load   : one-cycle strobe, accepted only while busy=0
//   value  : binary time in ms, 0..16383
//   mode   : 0 number, 1 "FAIL", 2 "IdLE", 3 all blank
//   blank  : level, forces all anodes off while high
//   busy   : high while a conversion is in progress (mirrors the FSM state)
//   done   : one-cycle pulse on the commit edge
//   bcd    : display code of the currently selected digit
//   an     : active-low anode selects, an[0] = units digit
//
// Handshake: load is a strobe with no back-pressure. It is consumed on a
// rising edge where busy=0 and dropped silently on an edge where busy=1.
// done pulses on the edge where busy falls.
module ssd_display_driver #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] value,
  input  logic [1:0]  mode,
  input  logic        blank,
  output logic        busy,
  output logic        done,
  output logic [4:0]  bcd,
  output logic [3:0]  an
);

  localparam logic [4:0] C_F   = 5'd10;
  localparam logic [4:0] C_A   = 5'd11;
  localparam logic [4:0] C_I   = 5'd12;
  localparam logic [4:0] C_L   = 5'd13;
  localparam logic [4:0] C_E   = 5'd14;
  localparam logic [4:0] C_D   = 5'd15;
  localparam logic [4:0] C_OFF = 5'd16;
  localparam logic [4:0] C_ERR = 5'd31;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [29:0]      sh;        // [29:14] BCD nibbles, [13:0] binary
  logic [29:0]      sh_adj;
  logic [29:0]      sh_step;
  logic [3:0]       iter;
  logic [1:0]       mode_q;
  logic             ovf_q;     // latched value > 9999
  logic             accept;
  logic             commit;
  logic [3:0][4:0]  disp;      // disp[i] is shown on an[i]
  logic [3:0][4:0]  disp_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  // One shift-add-3 step: correct each nibble, then shift the whole register.
  always_comb begin
    sh_adj = sh;
    for (int k = 0; k < 4; k++) begin
      if (sh[14 + 4*k +: 4] >= 4'd5) begin
        sh_adj[14 + 4*k +: 4] = sh[14 + 4*k +: 4] + 4'd3;
      end
    end
    sh_step = {sh_adj[28:0], 1'b0};
  end

  // FSM next state and strobes.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    commit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          accept   = 1'b1;
          state_nx = S_CONV;
        end
      end
      S_CONV: begin
        // The last iteration and the commit share one edge, so the result is
        // taken from sh_step rather than from the register.
        if (iter == 4'd1) begin
          commit   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Display contents computed from the final BCD word and the latched mode.
  always_comb begin
    logic [3:0] b3, b2, b1, b0;
    b3 = sh_step[29:26];
    b2 = sh_step[25:22];
    b1 = sh_step[21:18];
    b0 = sh_step[17:14];
    disp_nx = {C_OFF, C_OFF, C_OFF, C_OFF};
    case (mode_q)
      2'd0: begin
        if (ovf_q) begin
          disp_nx = {C_ERR, C_ERR, C_ERR, C_ERR};
        end else begin
          // Leading-zero blanking; the units digit always shows.
          disp_nx[3] = (b3 == 4'd0) ? C_OFF : {1'b0, b3};
          disp_nx[2] = (b3 == 4'd0 && b2 == 4'd0) ? C_OFF : {1'b0, b2};
          disp_nx[1] = (b3 == 4'd0 && b2 == 4'd0 && b1 == 4'd0) ? C_OFF : {1'b0, b1};
          disp_nx[0] = {1'b0, b0};
        end
      end
      2'd1:    disp_nx = {C_F, C_A, C_I, C_L};
      2'd2:    disp_nx = {C_I, C_D, C_L, C_E};
      default: disp_nx = {C_OFF, C_OFF, C_OFF, C_OFF};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sh     <= '0;
      iter   <= '0;
      mode_q <= '0;
      ovf_q  <= 1'b0;
      done   <= 1'b0;
      disp   <= {C_OFF, C_OFF, C_OFF, C_OFF};
    end else begin
      state <= state_nx;
      done  <= commit;
      if (accept) begin
        sh     <= {16'd0, value};
        iter   <= 4'd14;
        mode_q <= mode;
        ovf_q  <= (value > 14'd9999);
      end else if (state == S_CONV) begin
        sh   <= sh_step;
        iter <= iter - 4'd1;
      end
      if (commit) begin
        disp <= disp_nx;
      end
    end
  end

  // Scan counter runs regardless of conversion or blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign busy = (state == S_CONV);
  assign bcd  = disp[idx];
  assign an   = blank ? 4'b1111 : ~(4'b0001 << idx);

endmodule
